instruction_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch port and instruction memory.
//  - CPU side: responder to the CPU fetch (PC in, INSTRUCTION out, BUSYWAIT stall).
//  - Memory side: initiator of whole-block reads to the instruction memory (mem_read/mem_busywait).
//  - Replaces the combinational fetch path: hits return in the same cycle, misses stall the CPU.

---
 rtl/instruction_cache_pkg.sv | 35 +++
 rtl/instruction_cache_tag_array.sv | 39 +++
 rtl/instruction_cache.sv | 127 ++++++++++++
 tb/tb_instruction_cache.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Purpose: address field widths, block geometry, controller state encoding
//          and a word-select helper used by the cache top level.
// Ports:   none (package).
package instruction_cache_pkg;

  localparam int ADDR_BITS       = 10;
  localparam int INDEX_BITS      = 3;
  localparam int WORD_BITS       = 2;
  localparam int OFFSET_BITS     = WORD_BITS + 2;
  localparam int TAG_BITS        = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
  localparam int BLOCK_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int LINES           = 2 ** INDEX_BITS;
  localparam int BLOCK_BITS      = 32 * (2 ** WORD_BITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  // Pick one 32-bit word out of a block; word 0 sits in the low bits.
  function automatic logic [31:0] select_word(input logic [BLOCK_BITS-1:0] block,
                                              input logic [WORD_BITS-1:0] word);
    logic [31:0] result;
    case (word)
      2'd0:    result = block[31:0];
      2'd1:    result = block[63:32];
      2'd2:    result = block[95:64];
      default: result = block[127:96];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/instruction_cache_tag_array.sv
// Valid-bit and tag storage for the instruction cache, with a combinational
// lookup comparator. The asynchronous reset invalidates every line.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   lookup_index   line selected by the current fetch address
//   lookup_tag     tag of the current fetch address
//   hit            line is valid and its stored tag matches lookup_tag
//   write_en       install write_tag into line write_index and mark it valid
//   write_index    line being filled
//   write_tag      tag of the block being filled
module instruction_cache_tag_array
  import instruction_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  output logic                  hit,
  input  logic                  write_en,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [TAG_BITS-1:0]   write_tag
);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      tags  <= '{default: '0};
    end else if (write_en) begin
      valid[write_index] <= 1'b1;
      tags[write_index]  <= write_tag;
    end
  end

  assign hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and
// instruction memory. Hits answer in the same cycle; a miss stalls the CPU
// while a whole 16-byte block is read from memory and installed.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count.
// Ports:
//   CLK           clock
//   RESET         asynchronous active-low reset
//   PC            fetch byte address (bits [9:2] used)
//   INSTRUCTION   fetched word, valid while BUSYWAIT is low
//   BUSYWAIT      CPU must hold PC and stall
//   mem_read      block read request to memory
//   mem_address   block address {tag,index} of the request
//   mem_readdata  block returned by memory, word 0 in [31:0]
//   mem_busywait  memory still servicing the request
//   hit_count     (ICACHE_STATS_EN) cycles spent idle on a hit
//   miss_count    (ICACHE_STATS_EN) block fetches started
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                PC,
  output logic [31:0]                INSTRUCTION,
  output logic                       BUSYWAIT,
  output logic                       mem_read,
  output logic [BLOCK_ADDR_BITS-1:0] mem_address,
  input  logic [BLOCK_BITS-1:0]      mem_readdata,
  input  logic                       mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
`endif
);

  state_t state;
  state_t next_state;

  logic [WORD_BITS-1:0]       word_sel;
  logic [INDEX_BITS-1:0]      index;
  logic [TAG_BITS-1:0]        tag;
  logic                       hit;
  logic [BLOCK_ADDR_BITS-1:0] fill_addr;
  logic [BLOCK_BITS-1:0]      data_array [LINES];
  logic                       unused_pc;

  assign word_sel  = PC[OFFSET_BITS-1:2];
  assign index     = PC[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag       = PC[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS];
  assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

  instruction_cache_tag_array u_tags (
    .clk          (CLK),
    .rst_n        (RESET),
    .lookup_index (index),
    .lookup_tag   (tag),
    .hit          (hit),
    .write_en     (state == UPDATE),
    .write_index  (fill_addr[INDEX_BITS-1:0]),
    .write_tag    (fill_addr[BLOCK_ADDR_BITS-1:INDEX_BITS])
  );

  // The tag/valid write is deferred to UPDATE so the line only becomes a hit
  // after its data is already in place.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!hit) next_state = MEM_READ;
      MEM_READ: if (!mem_busywait) next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The miss address is latched on entry to MEM_READ so a wandering PC cannot
  // redirect a fill that is already in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fill_addr <= '0;
    end else if (state == IDLE && !hit) begin
      fill_addr <= {tag, index};
    end
  end

  // Memory data is only trusted in the cycle it stops asserting busywait.
  always_ff @(posedge CLK) begin
    if (state == MEM_READ && !mem_busywait) begin
      data_array[fill_addr[INDEX_BITS-1:0]] <= mem_readdata;
    end
  end

  // Outputs are forced quiet while RESET is held, even though the cleared
  // tag array would otherwise report a miss.
  always_comb begin
    mem_read    = RESET && (state == MEM_READ);
    mem_address = fill_addr;
    BUSYWAIT    = RESET && ((state != IDLE) || !hit);
    INSTRUCTION = '0;
    if (RESET && state == IDLE && hit) begin
      INSTRUCTION = select_word(data_array[index], word_sel);
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache. A small memory model answers
// block reads after a fixed latency; expected fetch results are queued when a
// PC is driven and popped when the cache releases BUSYWAIT.
module tb_instruction_cache;

  localparam int MEM_LATENCY = 5;
  localparam int MISS_STALL  = MEM_LATENCY + 2;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  int          req_count = 0;
  logic [5:0]  last_req_addr = '0;
  logic        prev_mem_read = 1'b0;
  int unsigned mem_cnt;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Contents of instruction memory: a distinct value per word.
  function automatic logic [31:0] word_of(input logic [5:0] blk, input logic [1:0] w);
    return {8'h1C, 6'b0, blk, w, 10'h2A5};
  endfunction

  function automatic logic [127:0] block_of(input logic [5:0] blk);
    return {word_of(blk, 2'd3), word_of(blk, 2'd2), word_of(blk, 2'd1), word_of(blk, 2'd0)};
  endfunction

  // Memory model: busy for the first MEM_LATENCY-1 cycles of a request,
  // garbage on the data bus until it releases.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) mem_cnt <= 0;
    else if (mem_read) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  assign mem_busywait = mem_read && (mem_cnt < MEM_LATENCY - 1);
  assign mem_readdata = mem_busywait ? {4{32'hDEADBEEF}} : block_of(mem_address);

  // Count distinct memory requests and remember the last address.
  always @(negedge CLK) begin
    if (mem_read && !prev_mem_read) begin
      req_count     = req_count + 1;
      last_req_addr = mem_address;
    end
    prev_mem_read = mem_read;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Drive one fetch at a negedge, wait for the stall to end and compare.
  task automatic fetch(input logic [31:0] pc, input bit exp_miss, input string name);
    int          stall;
    int          req0;
    logic [31:0] exp;
    req0 = req_count;
    PC   = pc;
    exp_q.push_back(word_of(pc[9:4], pc[3:2]));
    #1;
    stall = 0;
    while (BUSYWAIT === 1'b1 && stall < 50) begin
      @(negedge CLK);
      #1;
      stall++;
    end
    checks++;
    if (BUSYWAIT !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s timeout: BUSYWAIT=%b required 0", name, BUSYWAIT);
    end
    exp = exp_q.pop_front();
    checks++;
    if (INSTRUCTION !== exp) begin
      errors++;
      $display("[TB] FAIL %s instruction: got %h required %h", name, INSTRUCTION, exp);
    end
    checks++;
    if (stall != (exp_miss ? MISS_STALL : 0)) begin
      errors++;
      $display("[TB] FAIL %s stall: got %0d required %0d", name, stall, exp_miss ? MISS_STALL : 0);
    end
    checks++;
    if (req_count - req0 != (exp_miss ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s mem requests: got %0d required %0d", name, req_count - req0, exp_miss ? 1 : 0);
    end
    if (exp_miss) begin
      checks++;
      if (last_req_addr !== pc[9:4]) begin
        errors++;
        $display("[TB] FAIL %s mem_address: got %0d required %0d", name, last_req_addr, pc[9:4]);
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    PC    = 32'h0;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSYWAIT, mem_read, mem_address, INSTRUCTION} !== '0) begin
      errors++;
      $display("[TB] FAIL reset outputs: busy=%b rd=%b addr=%h instr=%h required all 0",
               BUSYWAIT, mem_read, mem_address, INSTRUCTION);
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 0 || miss_count !== 0) begin
      errors++;
      $display("[TB] FAIL reset counters: hit=%0d miss=%0d required 0", hit_count, miss_count);
    end
`endif
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(32'd0, 1'b1, "cold_miss");
  endtask

  task automatic test_spatial_hits();
    fetch(32'd4, 1'b0, "spatial_w1");
    fetch(32'd8, 1'b0, "spatial_w2");
    fetch(32'd12, 1'b0, "spatial_w3");
  endtask

  task automatic test_conflict_miss();
    fetch(32'd0, 1'b0, "conflict_pre_hit");
    fetch(32'd128, 1'b1, "conflict_tag1");
    fetch(32'd132, 1'b0, "conflict_tag1_hit");
    fetch(32'd0, 1'b1, "conflict_refill");
  endtask

  task automatic test_reset_mid_miss();
    PC = 32'd32;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 6'd2) begin
      errors++;
      $display("[TB] FAIL midmiss request: rd=%b addr=%0d required rd=1 addr=2", mem_read, mem_address);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || BUSYWAIT !== 1'b0 || mem_address !== 6'd0) begin
      errors++;
      $display("[TB] FAIL midmiss reset: rd=%b busy=%b addr=%0d required 0 0 0", mem_read, BUSYWAIT, mem_address);
    end
    @(negedge CLK);
    RESET = 1'b1;
    fetch(32'd0, 1'b1, "midmiss_refetch");
  endtask

  task automatic test_index_sweep();
    logic [31:0] hit0;
    apply_reset();
    for (int i = 0; i < 8; i++) fetch(32'(i * 16), 1'b1, "sweep_miss");
`ifdef ICACHE_STATS_EN
    checks++;
    if (miss_count !== 32'd8) begin
      errors++;
      $display("[TB] FAIL sweep miss_count: got %0d required 8", miss_count);
    end
    hit0 = hit_count;
`else
    hit0 = '0;
`endif
    for (int i = 0; i < 8; i++) fetch(32'(i * 16 + (i % 4) * 4), 1'b0, "sweep_hit");
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count - hit0 !== 32'd8) begin
      errors++;
      $display("[TB] FAIL sweep hit_count delta: got %0d required 8", hit_count - hit0);
    end
`endif
    if (hit0 === 32'hFFFF_FFFF) $display("[TB] note: hit counter near wrap");
  endtask

  task automatic test_upper_bits();
    fetch(32'h0000_0400, 1'b0, "upper_bits_w0");
    fetch(32'hFFFF_FC04, 1'b0, "upper_bits_w1");
  endtask

  initial begin
    RESET = 1'b0;
    PC    = 32'h0;
    test_reset();
    test_cold_miss();
    test_spatial_hits();
    test_conflict_miss();
    test_reset_mid_miss();
    test_index_sweep();
    test_upper_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
